byte_inc_sched: RTL

Job scheduler in front of the byte_inc engine. It accepts (base_addr, length) jobs from NUM_REQ requesters through a round-robin arbiter and launches each job with a single-cycle run pulse. It then tracks the engine's waitrequest_o busy window and reports completion with the requester ID and an error flag. It sits between software-facing job ports and byte_inc's base_addr_i/length_i/run_i/waitrequest_o.

---
 rtl/byte_inc_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/byte_inc_sched.sv
// Round-robin job scheduler in front of the byte_inc engine.
// One job in flight; completion reported with requester id and timeout flag.
module byte_inc_sched #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 10,
  parameter int ID_WIDTH      = $clog2(NUM_REQ),
  parameter int START_TIMEOUT = 4,
  parameter int DONE_TIMEOUT  = 16384,
  parameter int CNT_WIDTH     = $clog2(DONE_TIMEOUT+1)
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_length_i,
  output logic                          eng_run_o,
  output logic [ADDR_WIDTH-1:0]         eng_base_addr_o,
  output logic [ADDR_WIDTH-1:0]         eng_length_o,
  input  logic                          eng_waitrequest_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ID_WIDTH-1:0]           done_id_o,
  output logic                          done_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0]  r_wd;
  logic [CNT_WIDTH-1:0]  w_wd_nxt;
  logic                  r_done;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_done_id;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic [ID_WIDTH-1:0]   w_done_id_nxt;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win;
  logic [ADDR_WIDTH-1:0] w_sel_base;
  logic [ADDR_WIDTH-1:0] w_sel_len;
  logic                  w_accept;

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      logic [ID_WIDTH-1:0] c;
      c = ID_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid_i[c]) begin
        w_found = 1'b1;
        w_win   = c;
      end
    end
  end

  assign w_sel_base = req_base_addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_len  = req_length_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_accept   = (r_state == S_IDLE) && w_found;

  always_comb begin
    req_ready_o = '0;
    if (w_accept && !srst_i)
      req_ready_o[w_win] = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wd_nxt      = r_wd;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_done_id_nxt = r_id;
    eng_run_o     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_done_id_nxt = w_win;
        if (w_found) begin
          if (w_sel_len == '0) w_done_nxt  = 1'b1;
          else                 w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!eng_waitrequest_i) begin
          eng_run_o   = 1'b1;
          w_wd_nxt    = '0;
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (eng_waitrequest_i) begin
          w_wd_nxt    = '0;
          w_state_nxt = S_WAIT_DONE;
        end else if (r_wd == CNT_WIDTH'(START_TIMEOUT-1)) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!eng_waitrequest_i) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wd == CNT_WIDTH'(DONE_TIMEOUT-1)) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= ID_WIDTH'(NUM_REQ-1);
      r_id      <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_wd      <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wd      <= w_wd_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_done_id <= w_done_nxt ? w_done_id_nxt : '0;
      if (w_accept) begin
        r_id   <= w_win;
        r_ptr  <= w_win;
        r_base <= w_sel_base;
        r_len  <= w_sel_len;
      end
    end
  end

  assign eng_base_addr_o = eng_run_o ? r_base : '0;
  assign eng_length_o    = eng_run_o ? r_len : '0;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = r_done;
  assign done_id_o       = r_done_id;
  assign done_err_o      = r_err;

endmodule
